// File: rtl/ex_muldiv.sv
// EX-stage HI/LO multiply/divide unit: fixed-latency MULT/MULTU and 32-step restoring DIV/DIVU.
// Holds the pipeline through stall_req until the 64-bit {HI,LO} result is written.
module ex_muldiv #(
    parameter int unsigned MUL_CYCLES = 3,
    parameter int unsigned DIV_ITERS  = 32
) (
    input  logic        clk,
    input  logic        rset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        stall_req,
    output logic        done,
    output logic [63:0] hilo_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);
    localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS);

    // Magnitude of a two's-complement word; 0x80000000 maps to unsigned 2^31.
    function automatic logic [31:0] mag(input logic [31:0] x);
        logic [31:0] r;
        if (x[31]) begin
            r = 32'd0 - x;
        end else begin
            r = x;
        end
        return r;
    endfunction

    function automatic logic [63:0] ext64(input logic [31:0] x, input logic is_signed);
        return {{32{is_signed & x[31]}}, x};
    endfunction

    state_t      state_r;
    logic [5:0]  cnt_r;
    logic [1:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic        busy_r;
    logic        done_r;
    logic [63:0] hilo_r;

    logic        signed_s;
    logic [31:0] dvs_s;
    logic [31:0] dvd_s;
    logic [63:0] prod_s;
    logic [32:0] shift_s;
    logic [33:0] diff_s;
    logic [31:0] rem_nxt_s;
    logic        qbit_s;
    logic [31:0] hi_s;
    logic [31:0] lo_s;

    assign signed_s = ~op_r[0];
    assign prod_s   = ext64(a_r, signed_s) * ext64(b_r, signed_s);
    assign shift_s  = {rem_r, quo_r[31]};
    assign diff_s   = {1'b0, shift_s} - {2'b00, dvs_s};

    // Operand magnitudes, one restoring-division step, and final sign correction.
    always_comb begin
        dvs_s     = b_r;
        dvd_s     = a_r;
        rem_nxt_s = shift_s[31:0];
        qbit_s    = 1'b0;
        hi_s      = rem_r;
        lo_s      = quo_r;
        if (signed_s) begin
            dvs_s = mag(b_r);
            dvd_s = mag(a_r);
        end else begin
            dvs_s = b_r;
            dvd_s = a_r;
        end
        if (diff_s[33] == 1'b0) begin
            rem_nxt_s = diff_s[31:0];
            qbit_s    = 1'b1;
        end else begin
            rem_nxt_s = shift_s[31:0];
            qbit_s    = 1'b0;
        end
        if (signed_s && a_r[31]) begin
            hi_s = 32'd0 - rem_r;
        end else begin
            hi_s = rem_r;
        end
        // A zero divisor yields an all-ones quotient regardless of operand signs.
        if (b_r == 32'd0) begin
            lo_s = 32'hFFFF_FFFF;
        end else if (signed_s && (a_r[31] ^ b_r[31])) begin
            lo_s = 32'd0 - quo_r;
        end else begin
            lo_s = quo_r;
        end
    end

    // Control FSM with registered busy/done/hilo; flush takes priority over completion.
    always_ff @(posedge clk or negedge rset) begin
        if (!rset) begin
            state_r <= S_IDLE;
            cnt_r   <= 6'd0;
            op_r    <= 2'd0;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            rem_r   <= 32'd0;
            quo_r   <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hilo_r  <= 64'd0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start && !flush) begin
                        a_r     <= src_a;
                        b_r     <= src_b;
                        op_r    <= op;
                        cnt_r   <= 6'd0;
                        busy_r  <= 1'b1;
                        state_r <= op[1] ? S_DIV : S_MUL;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_MUL: begin
                    if (flush) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= 6'd0;
                    end else if (cnt_r == MUL_LAST) begin
                        hilo_r  <= prod_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        cnt_r   <= 6'd0;
                        state_r <= S_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                S_DIV: begin
                    if (flush) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= 6'd0;
                    end else if (cnt_r == 6'd0) begin
                        // First DIV cycle loads magnitudes; the 32 steps follow.
                        rem_r <= 32'd0;
                        quo_r <= dvd_s;
                        cnt_r <= 6'd1;
                    end else begin
                        rem_r <= rem_nxt_s;
                        quo_r <= {quo_r[30:0], qbit_s};
                        cnt_r <= cnt_r + 6'd1;
                        if (cnt_r == DIV_LAST) begin
                            state_r <= S_FIX;
                        end else begin
                            state_r <= S_DIV;
                        end
                    end
                end
                S_FIX: begin
                    if (flush) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= 6'd0;
                    end else begin
                        hilo_r  <= {hi_s, lo_s};
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        cnt_r   <= 6'd0;
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= 6'd0;
                end
            endcase
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign hilo_out  = hilo_r;
    assign stall_req = busy_r | (start & ~busy_r);

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: cycle-level reference model plus hand-computed result checks.
module tb_ex_muldiv;

    localparam int MULC = 3;
    localparam int DIVL = 34;

    logic        clk;
    logic        rset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [63:0] hilo_out;

    int total = 0;
    int bad   = 0;

    ex_muldiv #(.MUL_CYCLES(MULC), .DIV_ITERS(32)) dut (
        .clk       (clk),
        .rset      (rset),
        .start     (start),
        .op        (op),
        .src_a     (src_a),
        .src_b     (src_b),
        .flush     (flush),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hilo_out  (hilo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Architectural result from plain integer arithmetic.
    function automatic logic [63:0] model_fn(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] res;
        logic [63:0] q64;
        logic [63:0] r64;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        res = 64'd0;
        case (o)
            2'd0: res = 64'(sa * sb);
            2'd1: res = {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    q64 = 64'(q);
                    r64 = 64'(r);
                    res = {r64[31:0], q64[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) begin
                    res = {a, 32'hFFFF_FFFF};
                end else begin
                    res = {a % b, a / b};
                end
            end
        endcase
        return res;
    endfunction

    // Reference timeline: an accepted op completes after its latency unless flushed.
    logic        m_busy;
    logic        m_done;
    logic [63:0] m_hilo;
    logic [63:0] m_res;
    int          m_left;

    always @(posedge clk or negedge rset) begin
        if (!rset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_hilo <= 64'd0;
            m_res  <= 64'd0;
            m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (flush) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_hilo <= m_res;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (start && !flush) begin
                m_busy <= 1'b1;
                m_left <= op[1] ? DIVL : MULC;
                m_res  <= model_fn(op, src_a, src_b);
            end
        end
    end

    // Per-cycle comparison against the reference timeline.
    always @(negedge clk) begin
        if (rset) begin
            check("busy", 64'(busy), 64'(m_busy));
            check("done", 64'(done), 64'(m_done));
            check("hilo", hilo_out, m_hilo);
            check("stall_req", 64'(stall_req), 64'(m_busy | (start & ~m_busy)));
        end
    end

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat, input int hold, input string nm);
        int cyc;
        bit seen;
        @(posedge clk); #1;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        if (hold > 0) begin
            src_a = ~a;
            src_b = b + 32'd1;
        end else begin
            start = 1'b0;
        end
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 80) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == hold) start = 1'b0;
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check({nm, "_latency"}, 64'(cyc), 64'(lat));
        check({nm, "_result"}, hilo_out, exp);
    endtask

    initial begin
        rset = 1'b0; start = 1'b0; op = 2'd0; src_a = 32'd0; src_b = 32'd0; flush = 1'b0;
        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hilo", hilo_out, 64'd0);
        check("rst_stall", 64'(stall_req), 64'd0);
        #10 rset = 1'b1;

        check("model_mult", model_fn(2'd0, 32'hFFFF_FFFE, 32'd3), 64'hFFFF_FFFF_FFFF_FFFA);
        check("model_divovf", model_fn(2'd2, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        check("model_div0", model_fn(2'd2, 32'hFFFF_FF00, 32'd0), 64'hFFFF_FF00_FFFF_FFFF);

        run_op(2'd0, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, MULC, 0, "mult");
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MULC, 0, "multu");
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, DIVL, 0, "div_neg");
        run_op(2'd3, 32'd7, 32'd2, 64'h0000_0001_0000_0003, DIVL, 0, "divu");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIVL, 0, "div_ovf");
        run_op(2'd3, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF, DIVL, 0, "divu_zero");
        run_op(2'd2, 32'hFFFF_FF00, 32'd0, 64'hFFFF_FF00_FFFF_FFFF, DIVL, 0, "div_zero_neg");
        run_op(2'd2, 32'd100, 32'hFFFF_FFF9, 64'h0000_0002_FFFF_FFF2, DIVL, 0, "div_negdvs");

        // Flush a division in flight: no completion, previous result retained.
        @(posedge clk); #1;
        start = 1'b1; op = 2'd2; src_a = 32'd100; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hilo", hilo_out, 64'h0000_0002_FFFF_FFF2);
        repeat (3) @(negedge clk);
        run_op(2'd1, 32'd5, 32'd6, 64'h0000_0000_0000_001E, MULC, 0, "multu_after_flush");

        // Start held while busy must not re-latch operands.
        run_op(2'd0, 32'h0001_0000, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_0000, MULC, 2, "mult_hold");
        run_op(2'd3, 32'd100, 32'd7, 64'h0000_0002_0000_000E, DIVL, 5, "divu_hold");

        // Asynchronous reset between edges during a division.
        @(posedge clk); #1;
        start = 1'b1; op = 2'd2; src_a = 32'h0000_1000; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rset = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        check("arst_hilo", hilo_out, 64'd0);
        @(negedge clk);
        #2 rset = 1'b1;
        run_op(2'd0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, MULC, 0, "mult_after_rst");

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
